// File: rtl/regfile_pkg.sv
// Shared register-file parameters and the dump-reader FSM state type.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Debug readout: walks a wrapping register range through one read port and
// streams each value out on a valid/ready interface with register tag and last flag.
module regfile_dump_reader #(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    import regfile_pkg::*;

    dump_state_t       state, state_nx;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              hs;

    assign hs = out_valid & out_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   state_nx = abort ? IDLE : SEND;
            SEND: begin
                if (abort)   state_nx = IDLE;
                else if (hs) state_nx = out_last ? DONE : FETCH;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            end_addr  <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr <= first_addr;
                        end_addr <= last_addr;
                    end
                end
                FETCH: begin
                    // Snapshot taken here; later register-file writes are not reflected.
                    if (!abort) begin
                        out_data  <= rd_data;
                        out_addr  <= cur_addr;
                        out_last  <= (cur_addr == end_addr);
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else if (hs) begin
                        out_valid <= 1'b0;
                        // Power-of-two register count: natural overflow is the wrap.
                        if (!out_last) cur_addr <= cur_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_addr = cur_addr;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: table of dump ranges, random ranges,
// and hand-written backpressure / busy-start / abort / reset sequences.
module tb_regfile_dump_reader;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n, start, abort, out_ready;
    logic [ADDR_W-1:0] first_addr, last_addr, rd_addr, out_addr;
    logic [DATA_W-1:0] rd_data, out_data;
    logic              out_valid, out_last, busy, done;

    logic [DATA_W-1:0] regs [NUM_REGS];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    assign rd_data = regs[rd_addr];

    regfile_dump_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .first_addr(first_addr),
        .last_addr(last_addr), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    typedef struct {
        int first;
        int last;
        int pct;        // out_ready probability in percent
        int exp_cycles; // start edge to last handshake edge, -1 = unchecked
    } dump_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 64'h1111_1111_1111_1111 * 64'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NUM_REGS; i++) regs[i] = {$urandom, $urandom};
    endtask

    // Reference: the ordered list of register numbers a dump must produce.
    task automatic expected_range(input int first, input int last, output int q[$]);
        q = {};
        for (int n = 0; n < NUM_REGS; n++) begin
            q.push_back((first + n) % NUM_REGS);
            if ((first + n) % NUM_REGS == last) break;
        end
    endtask

    // Runs one dump to completion; stall_addr (if >=0) holds out_ready low for
    // four cycles while that register's beat is presented.
    task automatic run_dump(input int first, input int last, input int pct,
                            input int stall_addr, output int cycles);
        int q[$];
        int exp_a, stalls;
        bit held;
        logic [DATA_W-1:0] h_data;
        logic [ADDR_W-1:0] h_addr;
        logic h_last;
        expected_range(first, last, q);
        stalls = 0;
        held = 0;
        cycles = 0;
        first_addr = ADDR_W'(first);
        last_addr  = ADDR_W'(last);
        start = 1'b1;
        out_ready = 1'b0;
        step();
        start = 1'b0;
        while (q.size() > 0 && cycles < 2000) begin
            if (stall_addr >= 0 && out_valid && out_addr == ADDR_W'(stall_addr) && stalls < 4) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = ($urandom_range(0, 99) < pct);
            end
            #1;
            if (held) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", out_data, h_data);
                chk("hold_addr", 64'(out_addr), 64'(h_addr));
                chk("hold_last", 64'(out_last), 64'(h_last));
            end
            if (out_valid && out_ready) begin
                exp_a = q.pop_front();
                chk("beat_addr", 64'(out_addr), 64'(exp_a));
                chk("beat_data", out_data, regs[exp_a]);
                chk("beat_last", 64'(out_last), 64'(q.size() == 0));
            end
            held   = out_valid && !out_ready;
            h_data = out_data;
            h_addr = out_addr;
            h_last = out_last;
            step();
            cycles++;
        end
        chk("dump_complete_remaining", 64'(q.size()), 64'd0);
        out_ready = 1'b0;
        chk("done_after_last", 64'(done), 64'd1);
        chk("valid_after_last", 64'(out_valid), 64'd0);
        step();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    // Starts a 0..9 dump and kills it in SEND of the second beat, via abort or reset.
    task automatic kill_mid_dump(input bit use_reset, input string tag);
        bit found = 0;
        first_addr = '0;
        last_addr  = ADDR_W'(9);
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (out_valid && out_addr == ADDR_W'(1)) found = 1;
            else step();
        end
        chk({tag, "_reached_beat2"}, 64'(found), 64'd1);
        if (use_reset) reset_n = 1'b0;
        else           abort   = 1'b1;
        step();
        reset_n = 1'b1;
        abort   = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        step();
        chk({tag, "_no_done_later"}, 64'(done), 64'd0);
        chk({tag, "_stays_idle"}, 64'(busy), 64'd0);
    endtask

    dump_vec_t vecs[$];
    int cyc;

    initial begin
        reset_n = 1'b0; start = 1'b1; abort = 1'b0; out_ready = 1'b0;
        first_addr = ADDR_W'(4); last_addr = ADDR_W'(6);
        fill_pattern();

        // Reset held two cycles with start asserted.
        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        start = 1'b0;
        reset_n = 1'b1;
        step();
        chk("post_rst_idle", 64'(busy), 64'd0);

        vecs = '{
            '{first: 0,  last: 31, pct: 100, exp_cycles: 64},
            '{first: 30, last: 1,  pct: 100, exp_cycles: 8},
            '{first: 7,  last: 7,  pct: 100, exp_cycles: 2},
            '{first: 5,  last: 4,  pct: 100, exp_cycles: 64},
            '{first: 10, last: 12, pct: 50,  exp_cycles: -1},
            '{first: 31, last: 0,  pct: 70,  exp_cycles: -1}
        };
        foreach (vecs[i]) begin
            run_dump(vecs[i].first, vecs[i].last, vecs[i].pct, -1, cyc);
            if (vecs[i].exp_cycles >= 0)
                chk($sformatf("latency_%0d_%0d", vecs[i].first, vecs[i].last),
                    64'(cyc), 64'(vecs[i].exp_cycles));
        end

        // Backpressure on the middle beat.
        run_dump(3, 5, 100, 4, cyc);
        chk("bp_cycles", 64'(cyc), 64'd10);

        // Single register with a start issued while busy.
        first_addr = ADDR_W'(7);
        last_addr  = ADDR_W'(7);
        start = 1'b1;
        out_ready = 1'b0;
        step();
        first_addr = '0;
        last_addr  = ADDR_W'(3);
        step();
        chk("single_valid", 64'(out_valid), 64'd1);
        step();
        step();
        chk("single_addr_held", 64'(out_addr), 64'd7);
        chk("single_last", 64'(out_last), 64'd1);
        chk("single_data", out_data, regs[7]);
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        chk("single_done", 64'(done), 64'd1);
        step();
        chk("single_idle", 64'(busy), 64'd0);
        chk("single_no_new_beat", 64'(out_valid), 64'd0);

        kill_mid_dump(1'b0, "abort");
        kill_mid_dump(1'b1, "reset");
        run_dump(12, 14, 100, -1, cyc);

        // Random ranges, random data, random backpressure.
        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_dump($urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1),
                     $urandom_range(30, 100), -1, cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side companion to the 64-bit register file.
- On a start pulse, walks a contiguous, wrapping address range of the register file through one read port.
- Streams each 64-bit value out on a valid/ready interface, tagged with its register number and a last flag.
- Serves as the debug/trace readout path that observes architectural state without stalling the write-back path.

Parameters:
- NUM_REGS, 32, number of architectural registers (X0..X31); must be a power of two.
- DATA_W, 64, register width in bits.
- ADDR_W, 5, register index width; equals log2(NUM_REGS).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  begin a dump; sampled only in IDLE.
- first_addr  input  ADDR_W  first register to read; captured with start.
- last_addr  input  ADDR_W  final register to read; captured with start.
- abort  input  1  terminate the dump in progress.
- rd_addr  output  ADDR_W  register file read address; driven from the internal current-address register.
- rd_data  input  DATA_W  register file read data; combinational response to rd_addr in the same cycle.
- out_valid  output  1  out_data, out_addr and out_last hold a valid beat.
- out_ready  input  1  consumer accepts the beat; a handshake occurs when out_valid and out_ready are both 1 at a clock edge.
- out_data  output  DATA_W  captured register value.
- out_addr  output  ADDR_W  register number of out_data.
- out_last  output  1  set on the beat whose out_addr equals last_addr.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state goes to IDLE.
  - cur_addr, end_addr, rd_addr, out_data, out_addr all 0.
  - out_valid, out_last, busy, done all 0.
  - Reset takes priority over every other input, including mid-dump; the partial beat is discarded.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 -> cur_addr<=first_addr, end_addr<=last_addr, go to FETCH.
  - start=0 -> stay in IDLE.
- FETCH (exactly one cycle):
  - rd_addr=cur_addr.
  - At the edge: out_data<=rd_data, out_addr<=cur_addr, out_last<=(cur_addr==end_addr), out_valid<=1, go to SEND.
- SEND:
  - Hold out_valid=1. out_data, out_addr and out_last stay stable until the handshake.
  - On handshake:
    - out_valid<=0.
    - If out_last=1 -> go to DONE.
    - Otherwise cur_addr<=cur_addr+1 (modulo NUM_REGS) and go to FETCH.
- DONE: done=1 for this one cycle, then go to IDLE.
- Latency:
  - start accepted at edge E0 -> out_valid=1 after edge E1.
  - Throughput is one beat per 2 cycles with out_ready held high.
  - done is high in the cycle after the last handshake edge.
- Wrap-around:
  - first_addr>last_addr wraps through NUM_REGS-1 to 0.
  - first_addr==last_addr gives a single beat with out_last=1.
  - A full 32-register dump from any start point uses last_addr=first_addr-1.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, out_valid<=0, no done pulse.
  - abort is ignored in IDLE.
- start while busy: ignored. A new range is captured only in IDLE.
- Coherency: the value reported is rd_data sampled at the FETCH edge. Concurrent register-file writes to that register after FETCH are not reflected.
- Register-file zero/XZR semantics belong to the register file; this block adds none.

Decomposition:
- Shared package regfile_pkg holds NUM_REGS, DATA_W, ADDR_W and the dump_state_t enum (IDLE, FETCH, SEND, DONE).
- Single module; no sub-module is warranted. The address counter and FSM fit in one always_ff block plus one output-decode block.

Test Plan:
- Reset: reset_n=0 for 2 cycles with start=1 -> out_valid=0, busy=0, done=0, rd_addr=0, and no beat is issued.
- Full dump: register file preloaded with X_i=64'h1111_1111_1111_1111*i; first=0, last=31, out_ready=1.
  - Expect 32 beats, out_addr=0..31 in order, each with the correct data.
  - out_last only on addr 31; done one cycle later; 64 cycles from start to last handshake.
- Backpressure: first=3, last=5; out_ready=0 for 4 cycles on the beat with addr 4.
  - out_data=X4 and out_addr=4 stay stable throughout.
  - Sequence 3,4,5 with no duplicate or lost beats.
- Wrap: first=30, last=1 -> out_addr sequence 30,31,0,1; out_last only on 1.
- Single register and busy start: first=last=7 -> one beat with addr 7, out_last=1, then done.
  - A second start with first=0 asserted during SEND is ignored.
- Abort/reset mid-dump:
  - abort=1 in SEND of beat 2 of a 0..9 dump -> IDLE next cycle, out_valid=0, no done.
  - Repeat with reset_n=0 instead of abort -> identical result.
  - A fresh start afterwards dumps from its own first_addr.
